// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 default timing, pixel type and frame-size helpers shared by the scanner blocks
package vga_pkg;
  localparam int H_ACT_DEF  = 640;
  localparam int H_FP_DEF   = 16;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BP_DEF   = 48;
  localparam int V_ACT_DEF  = 480;
  localparam int V_FP_DEF   = 10;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BP_DEF   = 33;
  localparam int WIN_W      = 11;
  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;
  function automatic int h_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction
  function automatic int v_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction
  function automatic int sel_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-strobe divider, h/v counters and raw sync/active/position flags
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   CLK_DIV  = 2,
  parameter int   H_ACT    = H_ACT_DEF,
  parameter int   H_FP     = H_FP_DEF,
  parameter int   H_SYNC   = H_SYNC_DEF,
  parameter int   H_BP     = H_BP_DEF,
  parameter int   V_ACT    = V_ACT_DEF,
  parameter int   V_FP     = V_FP_DEF,
  parameter int   V_SYNC   = V_SYNC_DEF,
  parameter int   V_BP     = V_BP_DEF,
  parameter logic SYNC_ACT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             pix_en_o,
  output logic             frame_start_o,
  output logic             active_o,
  output logic             h_sync_o,
  output logic             v_sync_o,
  output logic [WIN_W-1:0] x_o,
  output logic [WIN_W-1:0] y_o
);
  localparam int H_TOTAL = h_total(H_ACT, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACT, V_FP, V_SYNC, V_BP);
  localparam int DIV_W   = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int H_OFS   = H_SYNC + H_BP;
  localparam int V_OFS   = V_SYNC + V_BP;
  logic [DIV_W-1:0] div_q, div_d;
  logic [HW-1:0]    h_q, h_d;
  logic [VW-1:0]    v_q, v_d;
  logic             h_wrap;
  always_comb begin
    pix_en_o      = div_q == DIV_W'(CLK_DIV - 1);
    h_wrap        = pix_en_o && h_q == HW'(H_TOTAL - 1);
    div_d         = pix_en_o ? '0 : div_q + 1'b1;
    h_d           = h_wrap ? '0 : pix_en_o ? h_q + 1'b1 : h_q;
    v_d           = !h_wrap ? v_q : v_q == VW'(V_TOTAL - 1) ? '0 : v_q + 1'b1;
    frame_start_o = pix_en_o && h_q == '0 && v_q == '0;
    active_o      = int'(h_q) >= H_OFS && int'(h_q) < H_OFS + H_ACT &&
                    int'(v_q) >= V_OFS && int'(v_q) < V_OFS + V_ACT;
    h_sync_o      = int'(h_q) < H_SYNC ? SYNC_ACT : ~SYNC_ACT;
    v_sync_o      = int'(v_q) < V_SYNC ? SYNC_ACT : ~SYNC_ACT;
    // only meaningful while active_o is high
    x_o           = WIN_W'(int'(h_q) - H_OFS);
    y_o           = WIN_W'(int'(v_q) - V_OFS);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
    end
  end
endmodule

// File: rtl/vga_frame_scanner.sv
// vga_frame_scanner: VGA timing plus runtime-sized image window scan with incremental fetch address
// and a 2-tick output pipeline that keeps rgb, syncs and blank aligned.
module vga_frame_scanner
  import vga_pkg::*;
#(
  parameter int   CLK_DIV  = 2,
  parameter int   H_ACT    = H_ACT_DEF,
  parameter int   H_FP     = H_FP_DEF,
  parameter int   H_SYNC   = H_SYNC_DEF,
  parameter int   H_BP     = H_BP_DEF,
  parameter int   V_ACT    = V_ACT_DEF,
  parameter int   V_FP     = V_FP_DEF,
  parameter int   V_SYNC   = V_SYNC_DEF,
  parameter int   V_BP     = V_BP_DEF,
  parameter logic SYNC_ACT = 1'b1,
  parameter int   N_SRC    = 2,
  parameter int   ADDR_W   = 20,
  parameter int   PIX_W    = 8,
  localparam int  SEL_W    = sel_width(N_SRC)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SEL_W-1:0]  src_sel,
  input  logic [WIN_W-1:0]  win_w,
  input  logic [WIN_W-1:0]  win_h,
  input  logic              transpose,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic              pix_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [SEL_W-1:0]  mem_sel,
  output logic              h_sync,
  output logic              v_sync,
  output logic              blank_n,
  output logic              sync_n,
  output logic [PIX_W-1:0]  rgb,
  output logic              frame_start
);
  logic              tick, fs, active, hs_raw, vs_raw, in_win, row_end;
  logic [WIN_W-1:0]  x, y, win_w_q, win_h_q;
  logic [SEL_W-1:0]  sel_q;
  logic              tr_q, in_win_q, hs_q, vs_q, blank_q, h_sync_q, v_sync_q, blank_n_q;
  logic [ADDR_W-1:0] row_base_q, row_base_d, addr_q, addr_d;
  logic [PIX_W-1:0]  rgb_q;
  vga_timing_gen #(
    .CLK_DIV(CLK_DIV), .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .SYNC_ACT(SYNC_ACT)
  ) u_timing (
    .clk(clk), .rst_n(rst_n), .pix_en_o(tick), .frame_start_o(fs), .active_o(active),
    .h_sync_o(hs_raw), .v_sync_o(vs_raw), .x_o(x), .y_o(y)
  );
  // row_base is the address of the row's first pixel: y*win_w row-major, y transposed
  always_comb begin
    in_win     = active && x < win_w_q && y < win_h_q;
    row_end    = in_win && (x == win_w_q - 1'b1 || x == WIN_W'(H_ACT - 1));
    addr_d     = !in_win ? '0 : x == '0 ? row_base_q : addr_q + (tr_q ? ADDR_W'(win_h_q) : ADDR_W'(1));
    row_base_d = fs ? '0 : row_end ? row_base_q + (tr_q ? ADDR_W'(1) : ADDR_W'(win_w_q)) : row_base_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q      <= '0;
      win_w_q    <= '0;
      win_h_q    <= '0;
      tr_q       <= 1'b0;
      row_base_q <= '0;
      addr_q     <= '0;
      in_win_q   <= 1'b0;
      hs_q       <= ~SYNC_ACT;
      vs_q       <= ~SYNC_ACT;
      blank_q    <= 1'b0;
      rgb_q      <= '0;
      h_sync_q   <= ~SYNC_ACT;
      v_sync_q   <= ~SYNC_ACT;
      blank_n_q  <= 1'b0;
    end else if (tick) begin
      if (fs) begin
        sel_q   <= int'(src_sel) < N_SRC ? src_sel : '0;
        win_w_q <= win_w;
        win_h_q <= win_h;
        tr_q    <= transpose;
      end
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      in_win_q   <= in_win;
      hs_q       <= hs_raw;
      vs_q       <= vs_raw;
      blank_q    <= active;
      rgb_q      <= in_win_q ? mem_rdata : '0;
      h_sync_q   <= hs_q;
      v_sync_q   <= vs_q;
      blank_n_q  <= blank_q;
    end
  end
  assign pix_en      = tick;
  assign frame_start = fs;
  assign mem_addr    = addr_q;
  assign mem_sel     = sel_q;
  assign rgb         = rgb_q;
  assign h_sync      = h_sync_q;
  assign v_sync      = v_sync_q;
  assign blank_n     = blank_n_q;
  assign sync_n      = 1'b0;
endmodule

// File: tb/tb_vga_frame_scanner.sv
// tb_vga_frame_scanner: directed checks of a shrunken 16x12 raster (25x17 total, 2 clk per pixel)
module tb_vga_frame_scanner;
  localparam int HT = 25;
  localparam int VT = 17;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  src_sel = '0;
  logic [10:0] win_w = '0, win_h = '0;
  logic        transpose = 1'b0;
  logic [7:0]  mem_rdata, rgb;
  logic [15:0] mem_addr;
  logic [1:0]  mem_sel;
  logic        pix_en, h_sync, v_sync, blank_n, sync_n, frame_start;
  int          compared = 0, mismatched = 0, ck = 0;
  typedef struct packed { int h; int v; int a; int r; } pt_t;

  vga_frame_scanner #(
    .CLK_DIV(2), .H_ACT(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACT(12), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_ACT(1'b1),
    .N_SRC(3), .ADDR_W(16), .PIX_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .src_sel(src_sel), .win_w(win_w), .win_h(win_h),
    .transpose(transpose), .mem_rdata(mem_rdata), .pix_en(pix_en), .mem_addr(mem_addr),
    .mem_sel(mem_sel), .h_sync(h_sync), .v_sync(v_sync), .blank_n(blank_n),
    .sync_n(sync_n), .rgb(rgb), .frame_start(frame_start)
  );

  always #5 clk = ~clk;
  assign mem_rdata = mem_addr[7:0] ^ {mem_sel, 6'b0};
  // reference time base: clocks since reset release; pixel tick k owns odd clock 2k+1
  always @(posedge clk or negedge rst_n)
    if (!rst_n) ck <= 0;
    else ck <= ck + 1;

  task automatic wait_tick(input int h, input int v);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(ck % 2 == 1 && ((ck - 1) / 2) % HT == h && ((ck - 1) / 2 / HT) % VT == v) && n < 2000);
    if (n >= 2000) begin
      compared++; mismatched++;
      $display("FAIL wait_tick(%0d,%0d): position never reached", h, v);
    end
  endtask

  task automatic test_reset();
    src_sel = 2'd0; win_w = 11'd16; win_h = 11'd12; transpose = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compared += 10;
    if (pix_en !== 1'b0) begin mismatched++; $display("FAIL rst_pix_en: got %b want 0", pix_en); end
    if (mem_addr !== 16'd0) begin mismatched++; $display("FAIL rst_mem_addr: got %0d want 0", mem_addr); end
    if (mem_sel !== 2'd0) begin mismatched++; $display("FAIL rst_mem_sel: got %0d want 0", mem_sel); end
    if (rgb !== 8'd0) begin mismatched++; $display("FAIL rst_rgb: got %0d want 0", rgb); end
    if (blank_n !== 1'b0) begin mismatched++; $display("FAIL rst_blank_n: got %b want 0", blank_n); end
    if (h_sync !== 1'b0) begin mismatched++; $display("FAIL rst_h_sync: got %b want 0", h_sync); end
    if (v_sync !== 1'b0) begin mismatched++; $display("FAIL rst_v_sync: got %b want 0", v_sync); end
    if (sync_n !== 1'b0) begin mismatched++; $display("FAIL rst_sync_n: got %b want 0", sync_n); end
    if (frame_start !== 1'b0) begin mismatched++; $display("FAIL rst_frame_start: got %b want 0", frame_start); end
    if (dut.u_timing.h_q !== '0 && pix_en === 1'b0) begin mismatched++; $display("FAIL rst_pix_idle: got %b want 0", pix_en); end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_timing();
    int hs = 0, vs = 0, bl = 0, fs = 0, r0 = -1, r1 = -1;
    logic prev = 1'b0;
    wait_tick(0, 0);
    for (int i = 0; i < 850; i++) begin
      if (h_sync) hs++;
      if (v_sync) vs++;
      if (blank_n) bl++;
      if (frame_start) fs++;
      if (h_sync && !prev) begin
        if (r0 < 0) r0 = i;
        else if (r1 < 0) r1 = i;
      end
      prev = h_sync;
      @(posedge clk);
      #1;
    end
    compared += 6;
    if (hs !== 136) begin mismatched++; $display("FAIL hsync_clks: got %0d want 136", hs); end
    if (vs !== 100) begin mismatched++; $display("FAIL vsync_clks: got %0d want 100", vs); end
    if (bl !== 384) begin mismatched++; $display("FAIL blank_clks: got %0d want 384", bl); end
    if (fs !== 1) begin mismatched++; $display("FAIL frame_start_count: got %0d want 1", fs); end
    if (r1 - r0 !== 50) begin mismatched++; $display("FAIL hsync_period: got %0d want 50", r1 - r0); end
    if (frame_start !== 1'b1) begin mismatched++; $display("FAIL frame_period: got %b want 1 at clk 850", frame_start); end
  endtask

  task automatic test_rowmajor();
    pt_t pts[6] = '{'{8, 5, 8, 0}, '{12, 6, 20, 83}, '{16, 6, 0, 87},
                    '{17, 6, 0, 0}, '{15, 8, 39, 102}, '{9, 9, 0, 0}};
    src_sel = 2'd1; win_w = 11'd8; win_h = 11'd5; transpose = 1'b0;
    wait_tick(0, 0);
    foreach (pts[i]) begin
      wait_tick(pts[i].h, pts[i].v);
      compared += 2;
      if (mem_addr !== 16'(pts[i].a)) begin mismatched++; $display("FAIL rowmajor_addr[%0d]: got %0d want %0d", i, mem_addr, pts[i].a); end
      if (rgb !== 8'(pts[i].r)) begin mismatched++; $display("FAIL rowmajor_rgb[%0d]: got %0d want %0d", i, rgb, pts[i].r); end
    end
    compared++;
    if (mem_sel !== 2'd1) begin mismatched++; $display("FAIL rowmajor_sel: got %0d want 1", mem_sel); end
  endtask

  task automatic test_transpose();
    pt_t pts[6] = '{'{8, 4, 0, 0}, '{9, 4, 5, 128}, '{10, 4, 10, 133},
                    '{23, 4, 75, 198}, '{8, 7, 3, 0}, '{13, 7, 28, 151}};
    src_sel = 2'd2; win_w = 11'd16; win_h = 11'd5; transpose = 1'b1;
    wait_tick(0, 0);
    foreach (pts[i]) begin
      wait_tick(pts[i].h, pts[i].v);
      compared += 2;
      if (mem_addr !== 16'(pts[i].a)) begin mismatched++; $display("FAIL transpose_addr[%0d]: got %0d want %0d", i, mem_addr, pts[i].a); end
      if (rgb !== 8'(pts[i].r)) begin mismatched++; $display("FAIL transpose_rgb[%0d]: got %0d want %0d", i, rgb, pts[i].r); end
    end
    compared++;
    if (mem_sel !== 2'd2) begin mismatched++; $display("FAIL transpose_sel: got %0d want 2", mem_sel); end
  endtask

  task automatic test_midframe();
    pt_t old_p[2] = '{'{9, 4, 5, 128}, '{13, 5, 26, 149}};
    pt_t new_p[3] = '{'{9, 4, 1, 0}, '{11, 5, 7, 6}, '{12, 5, 0, 7}};
    wait_tick(0, 2);
    src_sel = 2'd3; win_w = 11'd4; win_h = 11'd5; transpose = 1'b0;
    foreach (old_p[i]) begin
      wait_tick(old_p[i].h, old_p[i].v);
      compared += 2;
      if (mem_addr !== 16'(old_p[i].a)) begin mismatched++; $display("FAIL midframe_old_addr[%0d]: got %0d want %0d", i, mem_addr, old_p[i].a); end
      if (rgb !== 8'(old_p[i].r)) begin mismatched++; $display("FAIL midframe_old_rgb[%0d]: got %0d want %0d", i, rgb, old_p[i].r); end
    end
    compared++;
    if (mem_sel !== 2'd2) begin mismatched++; $display("FAIL midframe_old_sel: got %0d want 2", mem_sel); end
    wait_tick(0, 0);
    foreach (new_p[i]) begin
      wait_tick(new_p[i].h, new_p[i].v);
      compared += 2;
      if (mem_addr !== 16'(new_p[i].a)) begin mismatched++; $display("FAIL midframe_new_addr[%0d]: got %0d want %0d", i, mem_addr, new_p[i].a); end
      if (rgb !== 8'(new_p[i].r)) begin mismatched++; $display("FAIL midframe_new_rgb[%0d]: got %0d want %0d", i, rgb, new_p[i].r); end
    end
    compared++;
    if (mem_sel !== 2'd0) begin mismatched++; $display("FAIL midframe_clamped_sel: got %0d want 0", mem_sel); end
  endtask

  task automatic test_reset_mid();
    wait_tick(12, 6);
    rst_n = 1'b0;
    #1;
    compared += 6;
    if (pix_en !== 1'b0) begin mismatched++; $display("FAIL midrst_pix_en: got %b want 0", pix_en); end
    if (mem_addr !== 16'd0) begin mismatched++; $display("FAIL midrst_mem_addr: got %0d want 0", mem_addr); end
    if (rgb !== 8'd0) begin mismatched++; $display("FAIL midrst_rgb: got %0d want 0", rgb); end
    if (blank_n !== 1'b0) begin mismatched++; $display("FAIL midrst_blank_n: got %b want 0", blank_n); end
    if (h_sync !== 1'b0 || v_sync !== 1'b0) begin mismatched++; $display("FAIL midrst_sync: got %b%b want 00", h_sync, v_sync); end
    if (frame_start !== 1'b0) begin mismatched++; $display("FAIL midrst_frame_start: got %b want 0", frame_start); end
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    compared += 2;
    if (frame_start !== 1'b1) begin mismatched++; $display("FAIL restart_frame_start: got %b want 1", frame_start); end
    if (pix_en !== 1'b1) begin mismatched++; $display("FAIL restart_pix_en: got %b want 1", pix_en); end
    wait_tick(11, 5);
    compared += 2;
    if (mem_addr !== 16'd7) begin mismatched++; $display("FAIL restart_addr: got %0d want 7", mem_addr); end
    if (rgb !== 8'd6) begin mismatched++; $display("FAIL restart_rgb: got %0d want 6", rgb); end
  endtask

  task automatic test_window_edges();
    int nz_rgb = 0, nz_addr = 0, bl = 0;
    pt_t pts[5] = '{'{23, 4, 15, 78}, '{8, 5, 20, 0}, '{23, 15, 235, 170},
                    '{24, 15, 0, 171}, '{1, 16, 0, 0}};
    src_sel = 2'd1; win_w = 11'd0; win_h = 11'd5; transpose = 1'b0;
    wait_tick(0, 0);
    for (int i = 0; i < 850; i++) begin
      if (rgb !== 8'd0) nz_rgb++;
      if (mem_addr !== 16'd0) nz_addr++;
      if (blank_n) bl++;
      @(posedge clk);
      #1;
    end
    compared += 3;
    if (nz_rgb !== 0) begin mismatched++; $display("FAIL empty_win_rgb: got %0d nonzero want 0", nz_rgb); end
    if (nz_addr !== 0) begin mismatched++; $display("FAIL empty_win_addr: got %0d nonzero want 0", nz_addr); end
    if (bl !== 384) begin mismatched++; $display("FAIL empty_win_blank: got %0d want 384", bl); end
    win_w = 11'd20; win_h = 11'd15;
    wait_tick(0, 0);
    foreach (pts[i]) begin
      wait_tick(pts[i].h, pts[i].v);
      compared += 2;
      if (mem_addr !== 16'(pts[i].a)) begin mismatched++; $display("FAIL clip_addr[%0d]: got %0d want %0d", i, mem_addr, pts[i].a); end
      if (rgb !== 8'(pts[i].r)) begin mismatched++; $display("FAIL clip_rgb[%0d]: got %0d want %0d", i, rgb, pts[i].r); end
      if (i >= 3) begin
        compared++;
        if (blank_n !== (i == 3)) begin mismatched++; $display("FAIL clip_blank[%0d]: got %b want %b", i, blank_n, i == 3); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_rowmajor();
    test_transpose();
    test_midframe();
    test_reset_mid();
    test_window_edges();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
